// File: rtl/binarize_pack.sv
// binarize_pack: thresholds signed sums into bits and packs them LSB-first into PACK_W-bit words.
// Optional BINARIZE_PACK_STAT_EN adds the o_words emitted-word counter.
module binarize_pack #(
  parameter int ACC_W  = 12,
  parameter int PACK_W = 64,
  parameter int CNT_W  = $clog2(PACK_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_val,
  input  logic [ACC_W-1:0]  stream_i,
  input  logic [ACC_W-1:0]  thr_i,
  input  logic              i_last,
  output logic              o_val,
  output logic [PACK_W-1:0] stream_o,
  output logic [CNT_W-1:0]  o_cnt
`ifdef BINARIZE_PACK_STAT_EN
  ,
  output logic [15:0]       o_words
`endif
);
  localparam int IDX_W = $clog2(PACK_W);
  logic              s1_val_q, s1_bit_q, s1_last_q, s1_bit_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [PACK_W-1:0] pack_q, pack_d, word, stream_q, stream_d;
  logic [CNT_W-1:0]  o_cnt_q, o_cnt_d;
  logic              o_val_q, emit;
  always_comb begin
    s1_bit_d = $signed(stream_i) >= $signed(thr_i);
    word     = pack_q | (PACK_W'(s1_val_q & s1_bit_q) << cnt_q);
    // A flush with nothing accumulated and no beat this cycle emits nothing
    emit     = (s1_val_q && cnt_q == IDX_W'(PACK_W - 1)) || (s1_last_q && (s1_val_q || cnt_q != '0));
    stream_d = emit ? word : stream_q;
    o_cnt_d  = emit ? CNT_W'(cnt_q) + CNT_W'(s1_val_q) : o_cnt_q;
    pack_d   = emit ? '0 : word;
    cnt_d    = emit ? '0 : cnt_q + IDX_W'(s1_val_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_val_q  <= 1'b0;
      s1_bit_q  <= 1'b0;
      s1_last_q <= 1'b0;
      cnt_q     <= '0;
      pack_q    <= '0;
      o_val_q   <= 1'b0;
      stream_q  <= '0;
      o_cnt_q   <= '0;
    end else begin
      s1_val_q  <= i_val;
      s1_bit_q  <= s1_bit_d;
      s1_last_q <= i_last;
      cnt_q     <= cnt_d;
      pack_q    <= pack_d;
      o_val_q   <= emit;
      stream_q  <= stream_d;
      o_cnt_q   <= o_cnt_d;
    end
  end
  assign o_val    = o_val_q;
  assign stream_o = stream_q;
  assign o_cnt    = o_cnt_q;
`ifdef BINARIZE_PACK_STAT_EN
  logic [15:0] words_q, words_d;
  always_comb words_d = words_q + 16'(emit);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) words_q <= '0;
    else      words_q <= words_d;
  end
  assign o_words = words_q;
`endif
endmodule

// File: tb/tb_binarize_pack.sv
// tb_binarize_pack: randomized and directed checks of binarize_pack against a bit-queue packer model.
module tb_binarize_pack;
  logic        clk = 1'b0, rst_n = 1'b0, i_val = 1'b0, i_last = 1'b0;
  logic [11:0] stream_i = '0, thr_i = '0;
  logic        o_val;
  logic [63:0] stream_o;
  logic [6:0]  o_cnt;
`ifdef BINARIZE_PACK_STAT_EN
  logic [15:0] o_words;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit          bits[$];
  logic [63:0] exp_w[$], obs_w[$];
  int          exp_c[$], obs_c[$], exp_t[$], obs_t[$];

  binarize_pack dut (
    .clk(clk), .rst(rst_n), .i_val(i_val), .stream_i(stream_i), .thr_i(thr_i),
    .i_last(i_last), .o_val(o_val), .stream_o(stream_o), .o_cnt(o_cnt)
`ifdef BINARIZE_PACK_STAT_EN
    , .o_words(o_words)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_val === 1'b1) begin
    obs_w.push_back(stream_o); obs_c.push_back(int'(o_cnt)); obs_t.push_back(cyc);
  end

  // Reference: accumulate thresholded bits; a word leaves when 64 are held or a flush sees any
  task automatic send(input bit v, input int s, input int t, input bit l);
    logic [63:0] w;
    @(negedge clk);
    i_val = v; stream_i = s[11:0]; thr_i = t[11:0]; i_last = l;
    if (v) bits.push_back(s >= t);
    if ((v && bits.size() == 64) || (l && bits.size() > 0)) begin
      w = '0;
      foreach (bits[k]) w[k] = bits[k];
      exp_w.push_back(w); exp_c.push_back(bits.size()); exp_t.push_back(cyc + 2);
      bits.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048, 0);
  endtask

  task automatic clear_q;
    exp_w.delete(); exp_c.delete(); exp_t.delete(); obs_w.delete(); obs_c.delete(); obs_t.delete();
  endtask

  task automatic apply_reset;
    @(negedge clk); rst_n = 1'b0; i_val = 0; i_last = 0;
    bits.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic test_reset;
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_val !== 1'b0 || stream_o !== 64'h0 || o_cnt !== 7'd0) begin
      n_bad++; $display("FAIL reset_state: o_val=%b stream_o=%h o_cnt=%0d, want 0/0/0", o_val, stream_o, o_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic test_random;
    for (int b = 0; b < 128; b++) begin
      idle($urandom_range(0, 3));
      send(1, $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048, 0);
    end
    idle(4);
    n_cmp++;
    if (obs_w.size() != 2 || exp_w.size() != 2) begin
      n_bad++; $display("FAIL random_count: got %0d words, want 2 (model %0d)", obs_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      n_cmp++;
      if (obs_w[i] !== exp_w[i] || obs_c[i] !== 64 || obs_t[i] !== exp_t[i]) begin
        n_bad++; $display("FAIL random_word%0d: got %h/%0d@%0d, want %h/64@%0d", i, obs_w[i], obs_c[i], obs_t[i], exp_w[i], exp_t[i]);
      end
    end
`ifdef BINARIZE_PACK_STAT_EN
    n_cmp++;
    if (o_words !== 16'd2) begin
      n_bad++; $display("FAIL o_words: got %0d, want 2", o_words);
    end
`endif
    clear_q();
  endtask

  // Sends 64 beats from a generator pattern and checks the single resulting word
  task automatic full_word(input string nm, input int mode, input logic [63:0] want);
    for (int b = 0; b < 64; b++)
      case (mode)
        0: send(1, 3, 0, 0);
        1: send(1, (b % 2 == 0) ? 1 : -1, 0, 0);
        2: send(1, -7, -7, 0);
        default: send(1, -2048, 2047, 0);
      endcase
    idle(4);
    n_cmp++;
    if (obs_w.size() != 1) begin
      n_bad++; $display("FAIL %s_count: got %0d words, want 1", nm, obs_w.size());
    end
    if (obs_w.size() >= 1 && exp_w.size() >= 1) begin
      n_cmp++;
      if (obs_w[0] !== want || obs_c[0] !== 64 || obs_t[0] !== exp_t[0]) begin
        n_bad++; $display("FAIL %s: got %h/%0d@%0d, want %h/64@%0d", nm, obs_w[0], obs_c[0], obs_t[0], want, exp_t[0]);
      end
      n_cmp++;
      if (exp_w[0] !== want) begin
        n_bad++; $display("FAIL %s_model: model %h, want %h", nm, exp_w[0], want);
      end
    end
    clear_q();
  endtask

  task automatic test_full_words;
    full_word("all_ones", 0, 64'hFFFF_FFFF_FFFF_FFFF);
    full_word("alternate", 1, 64'h5555_5555_5555_5555);
    full_word("equal_thr", 2, 64'hFFFF_FFFF_FFFF_FFFF);
    full_word("extremes", 3, 64'h0);
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 128; b++) send(1, b[0] ? 5 : -5, 0, 0);
    idle(4);
    n_cmp++;
    if (obs_w.size() != 2) begin
      n_bad++; $display("FAIL b2b_count: got %0d words, want 2", obs_w.size());
    end else begin
      n_cmp++;
      if (obs_t[1] - obs_t[0] != 64 || obs_w[0] !== 64'hAAAA_AAAA_AAAA_AAAA || obs_w[1] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
        n_bad++; $display("FAIL b2b_words: got %h@%0d %h@%0d, want aaaaaaaaaaaaaaaa 64 cycles apart", obs_w[0], obs_t[0], obs_w[1], obs_t[1]);
      end
    end
    clear_q();
    for (int b = 0; b < 65; b++) send(1, 1, 0, b == 64);
    idle(4);
    n_cmp++;
    if (obs_w.size() != 2 || obs_c[0] !== 64 || obs_c[1] !== 1 || obs_t[1] - obs_t[0] != 1) begin
      n_bad++; $display("FAIL b2b_flush: got %0d words, want 64-bit then 1-bit on consecutive cycles", obs_w.size());
    end
    clear_q();
  endtask

  task automatic test_flush;
    send(1, 5, 0, 0); send(1, -5, 0, 0); send(1, 7, 0, 1);
    idle(4);
    n_cmp++;
    if (obs_w.size() != 1 || obs_w[0] !== 64'h5 || obs_c[0] !== 3 || obs_t[0] !== exp_t[0]) begin
      n_bad++; $display("FAIL partial_flush: got %0d words, first %h/%0d, want 1 word 5/3", obs_w.size(),
                        obs_w.size() ? obs_w[0] : 64'h0, obs_c.size() ? obs_c[0] : 0);
    end
    clear_q();
    send(0, 0, 0, 1);
    idle(4);
    n_cmp++;
    if (obs_w.size() != 0) begin
      n_bad++; $display("FAIL empty_flush: got %0d words, want 0", obs_w.size());
    end
    send(1, 1, 0, 0); send(1, 1, 0, 0); idle(5); send(0, 0, 0, 1);
    idle(4);
    n_cmp++;
    if (obs_w.size() != 1 || obs_w[0] !== 64'h3 || obs_c[0] !== 2 || obs_t[0] !== exp_t[0]) begin
      n_bad++; $display("FAIL gap_flush: got %0d words, want 1 word 3/2", obs_w.size());
    end
    clear_q();
  endtask

  task automatic test_midreset;
    for (int b = 0; b < 10; b++) send(1, -1, 0, 0);
    apply_reset();
    idle(3);
    n_cmp++;
    if (obs_w.size() != 0) begin
      n_bad++; $display("FAIL reset_discard: got %0d words, want 0", obs_w.size());
    end
    for (int b = 0; b < 64; b++) send(1, 1, 0, 0);
    idle(4);
    n_cmp++;
    if (obs_w.size() != 1 || obs_w[0] !== 64'hFFFF_FFFF_FFFF_FFFF || obs_c[0] !== 64 || obs_t[0] !== exp_t[0]) begin
      n_bad++; $display("FAIL reset_fresh: got %0d words, want 1 word ffffffffffffffff/64", obs_w.size());
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_random();
    test_full_words();
    test_back_to_back();
    test_flush();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
